// File: rtl/glyph_ram.sv
// glyph_ram: register-based glyph bitmap store with a 2-stage pixel read pipe, row writes and a serial glyph loader.
module glyph_ram #(
  parameter int GW = 3,
  parameter int GH = 5,
  parameter int NGLYPH = 4,
  localparam int XW = (GW > 1) ? $clog2(GW) : 1,
  localparam int YW = (GH > 1) ? $clog2(GH) : 1,
  localparam int GIW = (NGLYPH > 1) ? $clog2(NGLYPH) : 1
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           rd_en,
  input  logic [GIW-1:0] rd_glyph,
  input  logic [XW-1:0]  rd_x,
  input  logic [YW-1:0]  rd_y,
  output logic           data_out,
  output logic           rd_valid,
  input  logic           wr_en,
  input  logic [GIW-1:0] wr_glyph,
  input  logic [YW-1:0]  wr_row,
  input  logic [GW-1:0]  wr_data,
  input  logic           ld_start,
  input  logic [GIW-1:0] ld_glyph,
  input  logic           ld_valid,
  input  logic           ld_bit,
  output logic           ld_busy,
  output logic           ld_done
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam int NB = GW * GH;
  localparam int CW = $clog2(NB + 1);
  function automatic logic [GW-1:0] pat();
    for (int c = 0; c < GW; c++) pat[c] = (c % 2 == 0);
  endfunction
  localparam logic [GW-1:0] PAT = pat();
  logic [GW-1:0]  mem_q [NGLYPH][GH];
  logic [GW-1:0]  mem_d [NGLYPH][GH];
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [GIW-1:0] ldg_q, ldg_d;
  logic [GW-1:0]  row_q, row_d, sh;
  logic [XW-1:0]  col_q, col_d;
  logic           xok_q, xok_d, v1_q, v1_d, data_q, data_d, valid_q, valid_d;
  assign sh = row_q >> col_q;
  always_comb begin
    mem_d = mem_q;
    state_d = state_q;
    cnt_d = cnt_q;
    ldg_d = ldg_q;
    row_d = '0;
    for (int g = 0; g < NGLYPH; g++)
      for (int r = 0; r < GH; r++)
        if (rd_glyph == GIW'(g) && rd_y == YW'(r)) row_d = mem_q[g][r];
    for (int g = 0; g < NGLYPH; g++)
      for (int r = 0; r < GH; r++)
        if (wr_en && state_q != LOAD && wr_glyph == GIW'(g) && wr_row == YW'(r)) mem_d[g][r] = wr_data;
    // loader bit cnt maps row-major to row cnt/GW, column cnt%GW
    for (int g = 0; g < NGLYPH; g++)
      for (int r = 0; r < GH; r++)
        for (int c = 0; c < GW; c++)
          if (state_q == LOAD && ld_valid && ldg_q == GIW'(g) && cnt_q == CW'(r * GW + c)) mem_d[g][r][c] = ld_bit;
    col_d = rd_x;
    xok_d = int'(rd_x) < GW;
    v1_d = rd_en;
    data_d = v1_q ? (xok_q & sh[0]) : data_q;
    valid_d = v1_q;
    case (state_q)
      IDLE: if (ld_start && int'(ld_glyph) < NGLYPH) begin
        state_d = LOAD;
        cnt_d = '0;
        ldg_d = ld_glyph;
      end
      LOAD: if (ld_valid) begin
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(NB - 1)) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int g = 0; g < NGLYPH; g++)
        for (int r = 0; r < GH; r++) mem_q[g][r] <= PAT;
      state_q <= IDLE;
      cnt_q <= '0;
      ldg_q <= '0;
      row_q <= '0;
      col_q <= '0;
      xok_q <= 1'b0;
      v1_q <= 1'b0;
      data_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      ldg_q <= ldg_d;
      row_q <= row_d;
      col_q <= col_d;
      xok_q <= xok_d;
      v1_q <= v1_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign data_out = data_q;
  assign rd_valid = valid_q;
  assign ld_busy = state_q == LOAD;
  assign ld_done = state_q == DONE;
endmodule

// File: tb/tb_glyph_ram.sv
// tb_glyph_ram: directed checks of reads, row writes, serial load and reset abort on a default glyph_ram.
module tb_glyph_ram;
  logic       clock = 1'b0, rst_n = 1'b0;
  logic       rd_en = 1'b0, data_out, rd_valid;
  logic [1:0] rd_glyph = '0, rd_x = '0;
  logic [2:0] rd_y = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_glyph = '0;
  logic [2:0] wr_row = '0, wr_data = '0;
  logic       ld_start = 1'b0, ld_valid = 1'b0, ld_bit = 1'b0, ld_busy, ld_done;
  logic [1:0] ld_glyph = '0;
  int         checks = 0, errors = 0, dones = 0;
  glyph_ram dut (
    .clock(clock), .rst_n(rst_n), .rd_en(rd_en), .rd_glyph(rd_glyph), .rd_x(rd_x), .rd_y(rd_y),
    .data_out(data_out), .rd_valid(rd_valid), .wr_en(wr_en), .wr_glyph(wr_glyph), .wr_row(wr_row),
    .wr_data(wr_data), .ld_start(ld_start), .ld_glyph(ld_glyph), .ld_valid(ld_valid), .ld_bit(ld_bit),
    .ld_busy(ld_busy), .ld_done(ld_done)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic rd(input int g, input int y, input int x);
    rd_en = 1'b1;
    rd_glyph = 2'(g);
    rd_y = 3'(y);
    rd_x = 2'(x);
  endtask
  initial begin
    step();
    step();
    chk("rst data_out", data_out, 1'b0);
    chk("rst rd_valid", rd_valid, 1'b0);
    chk("rst ld_busy", ld_busy, 1'b0);
    chk("rst ld_done", ld_done, 1'b0);
    rst_n = 1'b1;
    step();
    rd(2, 4, 0);
    step();
    chk("pipe valid after 1", rd_valid, 1'b0);
    rd(2, 4, 1);
    step();
    chk("g2 y4 x0 data", data_out, 1'b1);
    chk("g2 y4 x0 valid", rd_valid, 1'b1);
    rd_en = 1'b0;
    step();
    chk("g2 y4 x1 data", data_out, 1'b0);
    chk("g2 y4 x1 valid", rd_valid, 1'b1);
    wr_en = 1'b1;
    wr_glyph = 2'd1;
    wr_row = 3'd3;
    wr_data = 3'b110;
    step();
    wr_en = 1'b0;
    rd(1, 3, 0);
    step();
    rd(1, 3, 1);
    step();
    chk("wr x0", data_out, 1'b0);
    rd(1, 3, 2);
    step();
    chk("wr x1", data_out, 1'b1);
    rd_en = 1'b0;
    step();
    chk("wr x2", data_out, 1'b1);
    chk("wr x2 valid", rd_valid, 1'b1);
    step();
    chk("idle valid", rd_valid, 1'b0);
    chk("idle hold", data_out, 1'b1);
    rd(0, 0, 3);
    step();
    rd(0, 5, 0);
    step();
    chk("oob x data", data_out, 1'b0);
    chk("oob x valid", rd_valid, 1'b1);
    rd(0, 0, 0);
    step();
    chk("oob y data", data_out, 1'b0);
    chk("oob y valid", rd_valid, 1'b1);
    rd(0, 7, 2);
    step();
    chk("inrange g0 y0 x0", data_out, 1'b1);
    rd_en = 1'b0;
    step();
    chk("oob y7 data", data_out, 1'b0);
    chk("oob y7 valid", rd_valid, 1'b1);
    rd(3, 0, 0);
    wr_en = 1'b1;
    wr_glyph = 2'd3;
    wr_row = 3'd0;
    wr_data = 3'b000;
    step();
    wr_en = 1'b0;
    rd(3, 0, 0);
    step();
    chk("rbw old value", data_out, 1'b1);
    rd_en = 1'b0;
    step();
    chk("rbw new value", data_out, 1'b0);
    ld_start = 1'b1;
    ld_glyph = 2'd0;
    step();
    ld_start = 1'b0;
    chk("ld busy rises", ld_busy, 1'b1);
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 1) begin
        ld_valid = 1'b0;
        step();
        chk("ld gap busy", ld_busy, 1'b1);
      end
      if (i == 5) begin
        wr_en = 1'b1;
        wr_glyph = 2'd2;
        wr_row = 3'd0;
        wr_data = 3'b010;
        ld_start = 1'b1;
        ld_glyph = 2'd1;
      end
      ld_valid = 1'b1;
      ld_bit = (i % 2 == 0);
      step();
      wr_en = 1'b0;
      ld_start = 1'b0;
      if (ld_done) dones++;
      if (i < 14) chk("ld busy", ld_busy, 1'b1);
    end
    ld_valid = 1'b0;
    chk("ld done pulse", ld_done, 1'b1);
    chk("ld busy at done", ld_busy, 1'b0);
    chk("ld done count", dones == 1, 1'b1);
    step();
    chk("ld done single", ld_done, 1'b0);
    chk("ld stays idle", ld_busy, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k < 15) rd(0, k / 3, k % 3);
      else rd_en = 1'b0;
      step();
      if (k >= 1) chk($sformatf("readback pix%0d", k - 1), data_out, ((k - 1) % 2 == 0));
    end
    rd(2, 0, 1);
    step();
    rd(1, 3, 0);
    step();
    chk("g2 row0 untouched", data_out, 1'b0);
    rd_en = 1'b0;
    step();
    chk("g1 row3 untouched", data_out, 1'b0);
    ld_start = 1'b1;
    ld_glyph = 2'd3;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_bit = 1'b0;
    for (int i = 0; i < 7; i++) step();
    ld_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("abort busy", ld_busy, 1'b0);
    chk("abort done", ld_done, 1'b0);
    rst_n = 1'b1;
    step();
    chk("abort no done", ld_done, 1'b0);
    rd(3, 0, 0);
    step();
    rd(3, 2, 0);
    step();
    chk("restored r0 x0", data_out, 1'b1);
    rd(3, 1, 2);
    step();
    chk("restored r2 x0", data_out, 1'b1);
    rd(3, 1, 1);
    step();
    chk("restored r1 x2", data_out, 1'b1);
    rd_en = 1'b0;
    step();
    chk("restored r1 x1", data_out, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
